// File: rtl/setpoint_adjust.sv
// Thermostat set-point: synchronizes and debounces up/down buttons, steps a clamped set-point, recalls default on both.
// Optional auto-repeat while held is built only when SETPOINT_AUTOREPEAT_EN is defined.
module setpoint_adjust #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 10_000_000,
  parameter int MIN_TEMP        = 50,
  parameter int MAX_TEMP        = 90,
  parameter int DEFAULT_TEMP    = 70
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [7:0] set_temp,
  output logic       step_pulse,
  output logic       at_limit
);

  localparam int         DW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam [DW-1:0]    DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] MIN_T    = 8'(MIN_TEMP);
  localparam logic [7:0] MAX_T    = 8'(MAX_TEMP);
  localparam logic [7:0] DEF_T    = 8'(DEFAULT_TEMP);
  localparam logic       LIMIT_RST = (DEFAULT_TEMP == MIN_TEMP) || (DEFAULT_TEMP == MAX_TEMP);

  typedef enum logic [1:0] {IDLE, HOLD_UP, HOLD_DN, BOTH} state_t;

  // bit 0 = up, bit 1 = down
  logic [1:0]         sync1, sync2, deb, deb_q;
  logic [1:0][DW-1:0] db_cnt;
  logic               up, dn, rise_up, rise_dn;
  state_t             state, state_nxt;
  logic               inc, dec, load, hold_run, rep_step;
  logic [7:0]         temp_nxt;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1  <= '0;
      sync2  <= '0;
      deb    <= '0;
      deb_q  <= '0;
      db_cnt <= '0;
    end else begin
      sync1 <= {btn_down, btn_up};
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign up      = deb[0];
  assign dn      = deb[1];
  assign rise_up = deb[0] & ~deb_q[0];
  assign rise_dn = deb[1] & ~deb_q[1];

  assign hold_run = ((state == HOLD_UP) && up && !dn) || ((state == HOLD_DN) && dn && !up);

`ifdef SETPOINT_AUTOREPEAT_EN
  localparam int      HMAX       = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int      HW         = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 1);
  localparam [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE - 1);

  logic [HW-1:0] hold_cnt;
  logic          repeating;

  assign rep_step = hold_run && (hold_cnt == (repeating ? RATE_LAST : DELAY_LAST));

  // Counts from the first step; keeps running even while the value is clamped.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else if (!hold_run) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else if (rep_step) begin
      hold_cnt  <= '0;
      repeating <= 1'b1;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  // Never true; keeps the repeat parameters referenced when auto-repeat is not built.
  assign rep_step = hold_run && (REPEAT_DELAY < 0) && (REPEAT_RATE < 0);
`endif

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (up && dn)    state_nxt = BOTH;
        else if (rise_up) state_nxt = HOLD_UP;
        else if (rise_dn) state_nxt = HOLD_DN;
      end
      HOLD_UP: begin
        if (!up)     state_nxt = IDLE;
        else if (dn) state_nxt = BOTH;
      end
      HOLD_DN: begin
        if (!dn)     state_nxt = IDLE;
        else if (up) state_nxt = BOTH;
      end
      BOTH: begin
        if (!up && !dn) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    inc  = 1'b0;
    dec  = 1'b0;
    load = 1'b0;
    case (state)
      IDLE: begin
        if (up && dn)     load = 1'b1;
        else if (rise_up) inc  = 1'b1;
        else if (rise_dn) dec  = 1'b1;
      end
      HOLD_UP: begin
        if (up && dn) load = 1'b1;
        else if (up)  inc  = rep_step;
      end
      HOLD_DN: begin
        if (up && dn) load = 1'b1;
        else if (dn)  dec  = rep_step;
      end
      default: ;
    endcase
  end

  always_comb begin
    temp_nxt = set_temp;
    if (load)                           temp_nxt = DEF_T;
    else if (inc && (set_temp != MAX_T)) temp_nxt = set_temp + 8'd1;
    else if (dec && (set_temp != MIN_T)) temp_nxt = set_temp - 8'd1;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      set_temp   <= DEF_T;
      step_pulse <= 1'b0;
      at_limit   <= LIMIT_RST;
    end else begin
      set_temp   <= temp_nxt;
      step_pulse <= (temp_nxt != set_temp);
      at_limit   <= (temp_nxt == MIN_T) || (temp_nxt == MAX_T);
    end
  end

endmodule
